// File: rtl/vec_delta_recon_if.sv
// Handshake bundle for vec_delta_recon.
// Ports (slave view, as seen by the decoder):
//   in_data/in_first/in_valid -> in_ready   : delta beats from the upstream subtract stage
//   out_data/out_valid/out_last <- out_ready : reconstructed absolute vectors
//   frame_done                               : pulse when a frame's last beat was accepted
interface vec_delta_recon_if #(
  parameter int unsigned DIMENSION = 16,
  parameter int unsigned WIDTH     = 8
);
  localparam int unsigned DW = DIMENSION * WIDTH;

  logic [DW-1:0] in_data;
  logic          in_first;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          frame_done;

  modport slave (
    input  in_data, in_first, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_done
  );

  modport master (
    output in_data, in_first, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_done
  );
endinterface

// File: rtl/vec_delta_recon.sv
// Per-lane delta decoder: rebuilds absolute vectors from lane differences,
// out = previous out + delta, over frames of FRAME_LEN beats. The first beat of
// a frame (or any beat arriving in IDLE) is taken as absolute.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-low
//   bus  - vec_delta_recon_if.slave (input beat stream, registered output stage,
//          frame_done pulse)
// Build option: define DELTA_SAT_EN for signed per-lane saturation of delta sums
// instead of modulo-2^WIDTH wrap.
module vec_delta_recon #(
  parameter int unsigned DIMENSION = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 64
) (
  input logic                clk,
  input logic                rst,
  vec_delta_recon_if.slave   bus
);

  localparam int unsigned DW = DIMENSION * WIDTH;
  localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] ref_q;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          is_abs;
  logic          last_beat;
  logic [DW-1:0] recon;
  logic [CW-1:0] cnt_inc;

  // Ready whenever the single output slot is empty or draining this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Per-lane reconstruction; lanes never interact.
  for (genvar i = 0; i < DIMENSION; i++) begin : g_lane
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;

    assign a = ref_q[i*WIDTH +: WIDTH];
    assign d = bus.in_data[i*WIDTH +: WIDTH];
    assign s = a + d;

`ifdef DELTA_SAT_EN
    logic ovf;
    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf = (a[WIDTH-1] == d[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    assign r   = !ovf        ? s :
                 a[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                               {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign r = s;
`endif

    assign recon[i*WIDTH +: WIDTH] = is_abs ? d : r;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = last_beat ? IDLE : RUN;
    end
  end

  // Beat classification and counter arithmetic.
  always_comb begin
    is_abs    = 1'b0;
    cnt_inc   = cnt + CW'(1);
    last_beat = 1'b0;
    if ((state == IDLE) || bus.in_first) begin
      is_abs = 1'b1;
    end
    if (is_abs) begin
      // Absolute beat starts a new count at 1.
      cnt_inc   = CW'(1);
      last_beat = (FRAME_LEN == 1);
    end else begin
      // cnt never reaches FRAME_LEN, so compare against the beat before it.
      last_beat = (cnt == CW'(FRAME_LEN - 1));
    end
  end

  // Output stage, reference and beat counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q          <= '0;
      cnt            <= '0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= accept && last_beat;
      if (accept) begin
        bus.out_data  <= recon;
        bus.out_valid <= 1'b1;
        bus.out_last  <= last_beat;
        ref_q         <= last_beat ? '0 : recon;
        cnt           <= last_beat ? '0 : cnt_inc;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_delta_recon.sv
// Directed bench for vec_delta_recon (DIMENSION=4, WIDTH=8, FRAME_LEN=4):
// a table of streamed beats with expected outputs, then hand-written
// backpressure, restart and mid-frame reset sequences.
module tb_vec_delta_recon;

  localparam int unsigned DIMENSION = 4;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned FRAME_LEN = 4;

  typedef struct {
    logic        first;
    logic [31:0] din;
    logic [31:0] dout;
    logic        last;
    logic        done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vec_delta_recon_if #(.DIMENSION(DIMENSION), .WIDTH(WIDTH)) bus ();

  vec_delta_recon #(
    .DIMENSION(DIMENSION),
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                     input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input logic f, input logic [31:0] di, input logic [31:0] dox,
                              input logic l, input logic d);
    vec_t v;
    v.first = f; v.din = di; v.dout = dox; v.last = l; v.done = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_data  = d;
  endtask

  task automatic chk_out(input string name, input logic [31:0] d, input logic l, input logic fd);
    chk({name, ".data"},  bus.out_data, d);
    chk({name, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".last"},  32'(bus.out_last), 32'(l));
    chk({name, ".done"},  32'(bus.frame_done), 32'(fd));
  endtask

  vec_t tbl [16];

  initial begin
    // Basic frame
    tbl[0]  = mk(1, pk(10, 20, 30, 40),   pk(10, 20, 30, 40), 0, 0);
    tbl[1]  = mk(0, pk(1, 1, 1, 1),       pk(11, 21, 31, 41), 0, 0);
    tbl[2]  = mk(0, pk(2, 0, 255, 5),     pk(13, 21, 30, 46), 0, 0);
    tbl[3]  = mk(0, pk(0, 0, 0, 0),       pk(13, 21, 30, 46), 1, 1);
    // Wrap in lane 0 (250 + 10); same result in signed mode (-6 + 10)
    tbl[4]  = mk(1, pk(250, 1, 2, 3),     pk(250, 1, 2, 3),   0, 0);
    tbl[5]  = mk(0, pk(10, 0, 0, 0),      pk(4, 1, 2, 3),     0, 0);
    tbl[6]  = mk(0, pk(0, 0, 0, 0),       pk(4, 1, 2, 3),     0, 0);
    tbl[7]  = mk(0, pk(0, 0, 0, 0),       pk(4, 1, 2, 3),     1, 1);
    // Overflow frame: 120+20 and -120+(-20)
    tbl[8]  = mk(1, pk(120, 8'h88, 0, 0), pk(120, 8'h88, 0, 0), 0, 0);
`ifdef DELTA_SAT_EN
    tbl[9]  = mk(0, pk(20, 8'hEC, 0, 0), pk(127, 8'h80, 0, 0), 0, 0);
    tbl[10] = mk(0, pk(0, 0, 1, 0),      pk(127, 8'h80, 1, 0), 0, 0);
    tbl[11] = mk(0, pk(0, 0, 0, 0),      pk(127, 8'h80, 1, 0), 1, 1);
`else
    tbl[9]  = mk(0, pk(20, 8'hEC, 0, 0), pk(8'h8C, 8'h74, 0, 0), 0, 0);
    tbl[10] = mk(0, pk(0, 0, 1, 0),      pk(8'h8C, 8'h74, 1, 0), 0, 0);
    tbl[11] = mk(0, pk(0, 0, 0, 0),      pk(8'h8C, 8'h74, 1, 0), 1, 1);
`endif
    // Frame started from IDLE without in_first: still absolute
    tbl[12] = mk(0, pk(9, 9, 9, 9),       pk(9, 9, 9, 9),     0, 0);
    tbl[13] = mk(0, pk(1, 2, 3, 4),       pk(10, 11, 12, 13), 0, 0);
    tbl[14] = mk(0, pk(255, 255, 255, 255), pk(9, 10, 11, 12), 0, 0);
    tbl[15] = mk(0, pk(1, 0, 0, 0),       pk(10, 10, 11, 12), 1, 1);

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset.data",  bus.out_data, 32'd0);
    chk("reset.valid", 32'(bus.out_valid), 32'd0);
    chk("reset.last",  32'(bus.out_last), 32'd0);
    chk("reset.done",  32'(bus.frame_done), 32'd0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b1;

    // Streamed table at full throughput
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].first, tbl[i].din);
      #1 chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk_out($sformatf("tbl%0d", i), tbl[i].dout, tbl[i].last, tbl[i].done);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("drain.valid", 32'(bus.out_valid), 32'd0);
    chk("drain.done",  32'(bus.frame_done), 32'd0);

    // Backpressure: hold output for 3 cycles, then release
    drive(1, pk(1, 2, 3, 4));
    @(negedge clk);
    chk_out("bp.a", pk(1, 2, 3, 4), 0, 0);
    bus.out_ready = 1'b0;
    drive(0, pk(1, 1, 1, 1));
    #1 chk("bp.in_ready0", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d.data", k), bus.out_data, pk(1, 2, 3, 4));
      chk($sformatf("bp.hold%0d.valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp.hold%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp.release.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk_out("bp.b", pk(2, 3, 4, 5), 0, 0);

    // Restart on beat 3 of the frame
    drive(1, pk(5, 5, 5, 5));
    @(negedge clk);
    chk_out("rs.first", pk(5, 5, 5, 5), 0, 0);
    drive(0, pk(0, 0, 0, 0));
    @(negedge clk);
    chk_out("rs.b2", pk(5, 5, 5, 5), 0, 0);
    drive(0, pk(1, 0, 0, 0));
    @(negedge clk);
    chk_out("rs.b3", pk(6, 5, 5, 5), 0, 0);
    drive(0, pk(0, 0, 0, 1));
    @(negedge clk);
    chk_out("rs.b4", pk(6, 5, 5, 6), 1, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rs.drain.valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-frame while output is held
    drive(1, pk(3, 3, 3, 3));
    @(negedge clk);
    drive(0, pk(1, 1, 1, 1));
    @(negedge clk);
    chk_out("mr.b2", pk(4, 4, 4, 4), 0, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    chk("mr.data",  bus.out_data, 32'd0);
    chk("mr.valid", 32'(bus.out_valid), 32'd0);
    chk("mr.last",  32'(bus.out_last), 32'd0);
    chk("mr.done",  32'(bus.frame_done), 32'd0);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(0, pk(7, 7, 7, 7));
    @(negedge clk);
    chk_out("mr.abs", pk(7, 7, 7, 7), 0, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_delta_recon.md
Name: vec_delta_recon

Overview:
- Per-lane delta decoder. Receives vectors of lane differences from the upstream vector subtract stage and rebuilds the absolute vectors: reconstructed = previous reconstructed + delta, per lane.
- Works on frames of FRAME_LEN vectors. The first beat of a frame is absolute. Every later beat is a delta against the previous output.
- Sits at the receive end of the difference path. Uses valid/ready handshakes on both sides, with a single registered output stage.

Parameters:
- DIMENSION, 16, number of lanes per vector.
- WIDTH, 8, bits per lane.
- FRAME_LEN, 64, beats per frame (>=1); counter width is clog2(FRAME_LEN), minimum 1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- in_data  input  DIMENSION*WIDTH  delta vector; lane i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
- in_first  input  1  marks the beat as frame start (absolute value); sampled with in_valid.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- out_data  output  DIMENSION*WIDTH  reconstructed vector, same lane packing.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_last  output  1  out_data is the final beat of its frame.
- frame_done  output  1  one-cycle pulse when the last beat of a frame is accepted at the input.

Behaviour:
- Reset (rst=0 at clk edge):
  - out_data=0, out_valid=0, out_last=0, frame_done=0.
  - Reference register=0, beat count=0, state=IDLE.
- in_ready = !out_valid || out_ready (combinational). An input beat is accepted when in_valid && in_ready.
- Latency: an accepted beat appears on out_data/out_valid the next cycle. Full throughput of 1 beat/cycle when out_ready=1.
- Output hold: while out_valid && !out_ready, out_data, out_valid and out_last hold, and in_ready=0.
- out_valid clears on out_ready unless a new beat is accepted in the same cycle.
- States:
  - IDLE: reference is 0. Any accepted beat starts a frame, whether or not in_first is set. out = in_data. Count becomes 1. Go to RUN, or stay in IDLE if FRAME_LEN=1.
  - RUN: accepted beat with in_first=0 gives out lane = ref lane + in lane, modulo 2^WIDTH (carry dropped). Count increments.
  - RUN: accepted beat with in_first=1 restarts the frame. out = in_data, count = 1, the previous frame is abandoned and frame_done does not pulse.
  - Every accepted beat writes its out value to the reference register.
- Frame end: when the accepted beat brings count to FRAME_LEN:
  - out_last=1 with that output beat.
  - frame_done pulses in the cycle after acceptance, aligned with out_valid.
  - Reference clears to 0, count clears to 0, state goes to IDLE.
- Lanes are independent; no inter-lane carries.
- Reset mid-frame: everything returns to reset values immediately and any held output is dropped.

Optional Feature:
- Macro DELTA_SAT_EN.
- Defined:
  - Lanes are two's-complement signed.
  - RUN-state sums saturate per lane to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Overflow is detected when both operands share a sign and the sum sign differs.
  - The saturated value is also stored as the reference.
- Not defined: plain modulo-2^WIDTH wrap as described above.
- Absolute beats (IDLE or in_first) are never altered in either mode.

Test Plan:
- Bench config for all scenarios: DIMENSION=4, WIDTH=8, FRAME_LEN=4.
- Basic frame: beats {10,20,30,40}(first), {1,1,1,1}, {2,0,255,5}, {0,0,0,0}, out_ready=1 -> outputs {10,20,30,40}, {11,21,31,41}, {13,21,30,46}, {13,21,30,46}; out_last on 4th; frame_done one pulse.
- Wrap: ref lane0=250, delta 10 -> 4 without DELTA_SAT_EN. With DELTA_SAT_EN: ref 120 + delta 20 -> 127, and ref -120 (0x88) + delta -20 (0xEC) -> -128 (0x80).
- Backpressure: hold out_ready=0 for 3 cycles after the first output -> in_ready=0, out_data stable; release -> next beat accepted same cycle, no loss or duplication.
- Restart: in_first=1 on beat 3 with value {5,5,5,5} -> output {5,5,5,5}, no frame_done; out_last on the 4th beat after the restart.
- Reset mid-frame: rst=0 for 1 cycle after beat 2 -> all outputs 0. Next beat {7,7,7,7} with in_first=0 -> output {7,7,7,7} (IDLE, absolute).
